// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encoding, FSM states
// and default latencies.
package mdu_sched_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Signed division works on magnitudes
// so the most-negative / -1 case falls out without a special path.
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] den_s;
  logic        [31:0] den_u;
  logic        [31:0] q_s;
  logic        [31:0] r_s;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisors are forced to 1 on zero so the dividers never see x/0.
  assign mag_a = mag32(a);
  assign mag_b = mag32(b);
  assign den_s = (b == 32'd0) ? 32'd1 : mag_b;
  assign den_u = (b == 32'd0) ? 32'd1 : b;
  assign q_s   = mag_a / den_s;
  assign r_s   = mag_a % den_s;

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        div_by_zero = (b == 32'd0);
        result      = {(a[31] ? neg32(r_s) : r_s),
                       ((a[31] ^ b[31]) ? neg32(q_s) : q_s)};
      end
      OP_DIVU: begin
        div_by_zero = (b == 32'd0);
        result      = {a % den_u, a / den_u};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle MDU scheduler: owns HI/LO, sequences mult/div latency and
// raises stall toward the hazard unit.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      opa_p0, opb_p0;
  logic [3:0]       op_p0;
  logic             load;
  logic             commit;
  logic [63:0]      result;
  logic             div_by_zero;

  mdu_arith u_arith (
    .op          (op_p0),
    .a           (opa_p0),
    .b           (opb_p0),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  // The edge that takes the counter from 1 to 0 is the commit edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_mul(op)) begin
          state_nxt = MUL_RUN;
          cnt_nxt   = CNT_W'(MULT_CYCLES);
          load      = 1'b1;
        end else if (start && is_div(op)) begin
          state_nxt = DIV_RUN;
          cnt_nxt   = CNT_W'(DIV_CYCLES);
          load      = 1'b1;
        end
      end
      default: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opa_p0 <= '0;
      opb_p0 <= '0;
      op_p0  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        opa_p0 <= src_a;
        opb_p0 <= src_b;
        op_p0  <= op;
      end
      if (commit && !div_by_zero) begin
        hi <= result[63:32];
        lo <= result[31:0];
      end else if (state == IDLE && start && op == OP_MTHI) begin
        hi <= src_a;
      end else if (state == IDLE && start && op == OP_MTLO) begin
        lo <= src_a;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = d_is_md & (busy | (start & (is_mul(op) | is_div(op))));

  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI)      rd_data = hi;
    else if (op == OP_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: expected HI/LO queued at issue, compared at
// completion, with cycle-exact busy/stall checks in between.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          q, r;
    model = {m_hi, m_lo};
    case (o)
      OP_MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        model = ps;
      end
      OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        model = pu;
      end
      OP_DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            model = {32'h0, 32'h8000_0000};
          end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            model = {r, q};
          end
        end
      end
      OP_DIVU: begin
        if (b != 0) model = {a % b, a / b};
      end
      default: ;
    endcase
  endfunction

  task automatic pop_and_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  // k_in > 0 injects a stray MULT start during run cycle k_in.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic dmd, input int k_in);
    int n;
    n = is_mul(o) ? MC : DC;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; d_is_md = dmd;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    check({tag, "_busy_t0"}, busy, 1'b0);
    check({tag, "_stall_t0"}, stall, dmd);
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k_in > 0 && k == k_in + 1) begin
        start = 1'b0; op = OP_NONE;
      end
      if (k <= n) begin
        check({tag, "_busy_run"}, busy, 1'b1);
        check({tag, "_stall_run"}, stall, dmd);
      end else begin
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_stall_done"}, stall, 1'b0);
        pop_and_check(tag);
      end
      if (k_in > 0 && k == k_in) begin
        start = 1'b1; op = OP_MULT; src_a = 32'h1111; src_b = 32'h2222;
      end
    end
  endtask

  task automatic do_mt(input string tag, input logic [3:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = v; src_b = 32'h0;
    sb_q.push_back((o == OP_MTHI) ? {v, m_lo} : {m_hi, v});
    @(posedge clk); #1;
    start = 1'b0;
    op = (o == OP_MTHI) ? OP_MFHI : OP_MFLO;
    @(negedge clk);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rd"}, rd_data, v);
    pop_and_check(tag);
    op = OP_NONE;
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = OP_NONE; src_a = '0; src_b = '0; d_is_md = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    op = OP_MFHI; #1;
    check("rst_mfhi", rd_data, 32'h0);
    op = OP_MFLO; #1;
    check("rst_mflo", rd_data, 32'h0);
    op = OP_NONE;

    do_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 2);
    check("multu_hi_const", hi, 32'h0000_0001);
    check("multu_lo_const", lo, 32'hFFFF_FFFE);
    do_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    do_op("divu0", OP_DIVU, 32'd7, 32'd0, 1'b0, DC);
    check("divu0_hi_const", hi, 32'hFFFF_FFFF);
    do_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("divovf_lo_const", lo, 32'h8000_0000);
    do_op("divu", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0, 0);
    do_op("multmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    do_op("divneg", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1, 0);

    do_mt("mtlo", OP_MTLO, 32'h0000_1234);
    do_mt("mthi", OP_MTHI, 32'hABCD_0001);

    // Undefined and NONE ops must not start anything.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd15; d_is_md = 1'b1;
    @(posedge clk); #1;
    op = OP_NONE;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("undef_busy", busy, 1'b0);
    check("undef_hi", hi, m_hi);
    check("undef_lo", lo, m_lo);

    for (int i = 0; i < 6; i++) begin
      ro = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
      do_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    // Reset during cycle 3 of a divide aborts it.
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd3; d_is_md = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("abort_busy_c3", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy_c4", busy, 1'b0);
    check("abort_stall_c4", stall, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (12) @(negedge clk);
    check("abort_hi_late", hi, 32'h0);
    check("abort_lo_late", lo, 32'h0);
    check("abort_busy_late", busy, 1'b0);

    // Reset wins over a simultaneous start.
    do_mt("mthi2", OP_MTHI, 32'h0000_5555);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; op = OP_NONE;
    @(negedge clk);
    check("rst_start_busy", busy, 1'b0);
    check("rst_start_hi", hi, 32'h0);
    check("rst_start_lo", lo, 32'h0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: E-stage instruction is a valid, non-flushed MDU op this cycle.
REQ-006 SHALL have port op  input  4: MDU op code; encoding in REQ-038.
REQ-007 SHALL have port src_a  input  32: forwarded rs value from E stage.
REQ-008 SHALL have port src_b  input  32: forwarded rt value from E stage.
REQ-009 SHALL have port d_is_md  input  1: D-stage instruction is any MDU op.
REQ-010 SHALL have port busy  output  1: multi-cycle operation in progress.
REQ-011 SHALL have port stall  output  1: stall request to the hazard unit (freeze F/D, bubble E).
REQ-012 SHALL have port hi  output  32: architectural HI register.
REQ-013 SHALL have port lo  output  32: architectural LO register.
REQ-014 SHALL have port rd_data  output  32: mfhi/mflo result for the E-stage writeback source.

Function
REQ-015 SHALL implement FSM states IDLE, MUL_RUN, DIV_RUN; busy SHALL be 1 exactly when state != IDLE.
REQ-016 IDLE with start=1 and op in {MULT,MULTU} SHALL latch src_a/src_b, load the counter with MULT_CYCLES, and go to MUL_RUN.
REQ-017 IDLE with start=1 and op in {DIV,DIVU} SHALL latch operands, load the counter with DIV_CYCLES, and go to DIV_RUN.
REQ-018 In a RUN state, the counter SHALL decrement each cycle; the edge at which it reaches 0 SHALL commit the result to HI/LO and return to IDLE.
REQ-019 Start in cycle t SHALL give busy=1 for cycles t+1..t+N, with the new HI/LO visible from cycle t+N+1.
REQ-020 MULT SHALL form the signed 64-bit product; MULTU SHALL form the unsigned 64-bit product; {HI,LO} SHALL be set to the product.
REQ-021 DIV SHALL set LO to the signed quotient (truncated toward zero) and HI to the remainder (sign of the dividend); DIVU SHALL do the same unsigned.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 Divisor 0 SHALL leave HI/LO unchanged and SHALL still keep busy high for DIV_CYCLES.
REQ-024 start=1 with MTHI (or MTLO) SHALL write src_a to HI (or LO) at the next edge, with no busy.
REQ-025 rd_data SHALL be combinational: hi when op=MFHI, lo when op=MFLO, else 0.
REQ-026 stall SHALL equal d_is_md & (busy | (start & op in {MULT,MULTU,DIV,DIVU})).
REQ-027 start while busy=1 SHALL be ignored, with no state, counter or HI/LO change.
REQ-028 start with op=NONE or an undefined code SHALL be ignored.
REQ-029 The commit cycle SHALL not accept a new start; the next op is accepted from the first IDLE cycle.
REQ-030 The counter width SHALL be sized for max(MULT_CYCLES, DIV_CYCLES) and SHALL never wrap below 0.

Reset
REQ-031 reset=1 SHALL force state=IDLE, counter=0, hi=0, lo=0, and latched operands=0.
REQ-032 reset=1 SHALL give busy=0 and stall=0 from the following cycle.
REQ-033 reset asserted mid-operation SHALL abort the operation with no HI/LO commit.
REQ-034 reset SHALL override a start in the same cycle.
REQ-035 rd_data SHALL follow REQ-025 after reset, reading 0 for MFHI/MFLO.

Structure
REQ-036 The shared package SHALL hold the op encoding, FSM state typedef, and MULT/DIV default cycle constants.
REQ-037 SHALL contain one combinational sub-module, mdu_arith: inputs op and two 32-bit operands, outputs 64-bit {hi,lo} result plus a div_by_zero flag.
REQ-038 Op encoding SHALL be NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.

Verification
REQ-039 MULT 0xFFFFFFFE x 3 at cycle 0 -> busy cycles 1..5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA at cycle 6.
REQ-040 MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-041 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; DIVU 7/0 -> HI/LO unchanged, busy still 10 cycles.
REQ-042 d_is_md=1 held during MULT -> stall=1 in start cycle and cycles 1..5, stall=0 at cycle 6; d_is_md=0 -> stall=0 throughout.
REQ-043 reset at cycle 3 of DIV 100/3 -> busy=0 at cycle 4, hi=lo=0, no later commit.
REQ-044 MTLO 0x1234 then MFLO next cycle -> rd_data=0x00001234, busy stays 0; second start while busy -> ignored.
